// File: rtl/issue_rat_prf_prefetch.sv
// Prefetch queue between the PRF free list and rename; drains unallocated PRFs back on flush.
// Optional combinational empty-queue bypass under ISSUE_RAT_PREFETCH_BYPASS_EN.
module issue_rat_prf_prefetch #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned PRF_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRF_WIDTH-1:0]  i_acquire_prf,
    input  logic                  i_acquire_valid,
    output logic                  o_acquire_ready,
    output logic [PRF_WIDTH-1:0]  o_alloc_prf,
    output logic                  o_alloc_valid,
    input  logic                  i_alloc_ready,
    output logic [PRF_WIDTH-1:0]  o_abandoned_prf,
    output logic                  o_abandoned_valid,
    input  logic                  i_abandoned_ready,
    input  logic                  i_flush,
    output logic                  o_draining,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CntOne    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [PRF_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic                  run, full, empty, accept;
    logic                  push, pop;
    logic [PRF_WIDTH-1:0]  head;

    assign run   = (state_q == StRun);
    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    // Flush blocks both RUN-side handshakes in its own cycle.
    assign accept = run & ~i_flush;

    always_comb begin
        o_acquire_ready   = accept & ~full;
        o_abandoned_valid = ~run;
        o_abandoned_prf   = head;
        o_draining        = ~run;
        o_count           = count_q;
`ifdef ISSUE_RAT_PREFETCH_BYPASS_EN
        // Empty queue forwards the offered PRF; it is queued only if rename does not take it.
        if (accept & empty) begin
            o_alloc_valid = i_acquire_valid;
            o_alloc_prf   = i_acquire_prf;
            push          = i_acquire_valid & o_acquire_ready & ~i_alloc_ready;
            pop           = 1'b0;
        end else begin
            o_alloc_valid = accept & ~empty;
            o_alloc_prf   = head;
            push          = i_acquire_valid & o_acquire_ready;
            pop           = o_alloc_valid & i_alloc_ready;
        end
`else
        o_alloc_valid = accept & ~empty;
        o_alloc_prf   = head;
        push          = i_acquire_valid & o_acquire_ready;
        pop           = o_alloc_valid & i_alloc_ready;
`endif
        pop = pop | (o_abandoned_valid & i_abandoned_ready);
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        unique case (state_q)
            StRun:   if (i_flush && !empty) state_d = StDrain;
            StDrain: if (pop && count_q == CntOne) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_acquire_prf;
    end

endmodule

// File: tb/tb_issue_rat_prf_prefetch.sv
// Directed bench for issue_rat_prf_prefetch: fill, pop/refill, steady-state wrap, drain, bypass.
module tb_issue_rat_prf_prefetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] i_acquire_prf;
    logic       i_acquire_valid;
    logic       o_acquire_ready;
    logic [5:0] o_alloc_prf;
    logic       o_alloc_valid;
    logic       i_alloc_ready;
    logic [5:0] o_abandoned_prf;
    logic       o_abandoned_valid;
    logic       i_abandoned_ready;
    logic       i_flush;
    logic       o_draining;
    logic [2:0] o_count;

    int tests = 0;
    int fails = 0;

    issue_rat_prf_prefetch #(.DEPTH_LOG2(2), .PRF_WIDTH(6)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_acquire_prf     (i_acquire_prf),
        .i_acquire_valid   (i_acquire_valid),
        .o_acquire_ready   (o_acquire_ready),
        .o_alloc_prf       (o_alloc_prf),
        .o_alloc_valid     (o_alloc_valid),
        .i_alloc_ready     (i_alloc_ready),
        .o_abandoned_prf   (o_abandoned_prf),
        .o_abandoned_valid (o_abandoned_valid),
        .i_abandoned_ready (i_abandoned_ready),
        .i_flush           (i_flush),
        .o_draining        (o_draining),
        .o_count           (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1ns later.
    task automatic step(input logic av, input logic [5:0] ap, input logic ar,
                        input logic fl, input logic abr);
        @(negedge clk);
        i_acquire_valid   = av;
        i_acquire_prf     = ap;
        i_alloc_ready     = ar;
        i_flush           = fl;
        i_abandoned_ready = abr;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_acquire_valid = 1'b0; i_acquire_prf = '0; i_alloc_ready = 1'b0;
        i_flush = 1'b0; i_abandoned_ready = 1'b0;
        #2;
        chk("rst_acq_ready", o_acquire_ready, 1);
        chk("rst_alloc_valid", o_alloc_valid, 0);
        chk("rst_aband_valid", o_abandoned_valid, 0);
        chk("rst_draining", o_draining, 0);
        chk("rst_count", o_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill: 5,7,9,11 taken, 13 refused at full.
        step(1, 5, 0, 0, 0);  chk("fill0_ready", o_acquire_ready, 1);
        step(1, 7, 0, 0, 0);  chk("fill1_ready", o_acquire_ready, 1);
                              chk("fill1_alloc_prf", o_alloc_prf, 5);
        step(1, 9, 0, 0, 0);  chk("fill2_ready", o_acquire_ready, 1);
        step(1, 11, 0, 0, 0); chk("fill3_ready", o_acquire_ready, 1);
        step(1, 13, 0, 0, 0); chk("fill4_ready", o_acquire_ready, 0);
                              chk("fill4_count", o_count, 4);
        step(1, 13, 0, 0, 0); chk("full_hold_ready", o_acquire_ready, 0);
                              chk("full_alloc_prf", o_alloc_prf, 5);

        // Pop four; 13 accepted one cycle after the first pop.
        step(1, 13, 1, 0, 0); chk("pop0_prf", o_alloc_prf, 5);
                              chk("pop0_ready", o_acquire_ready, 0);
                              chk("pop0_count", o_count, 4);
        step(1, 13, 1, 0, 0); chk("pop1_prf", o_alloc_prf, 7);
                              chk("pop1_ready", o_acquire_ready, 1);
                              chk("pop1_count", o_count, 3);
        step(0, 0, 1, 0, 0);  chk("pop2_prf", o_alloc_prf, 9);
                              chk("pop2_count", o_count, 3);
        step(0, 0, 1, 0, 0);  chk("pop3_prf", o_alloc_prf, 11);
                              chk("pop3_count", o_count, 2);
        step(0, 0, 0, 0, 0);  chk("after_pop_count", o_count, 1);
                              chk("after_pop_prf", o_alloc_prf, 13);

        // Steady state at count 2 across pointer wrap.
        step(1, 15, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 6'(16 + i), 1, 0, 0);
            chk("steady_count", o_count, 2);
            chk("steady_valid", o_alloc_valid, 1);
            chk("steady_prf", o_alloc_prf, (i == 0) ? 13 : (i == 1) ? 15 : 14 + i);
        end
        step(0, 0, 1, 0, 0);  chk("empty0_prf", o_alloc_prf, 24);
        step(0, 0, 1, 0, 0);  chk("empty1_prf", o_alloc_prf, 25);
        step(0, 0, 0, 0, 0);  chk("empty_count", o_count, 0);
                              chk("empty_valid", o_alloc_valid, 0);

        // Load {20,22,24} and flush.
        step(1, 20, 0, 0, 0);
        step(1, 22, 0, 0, 0);
        step(1, 24, 0, 0, 0);
        step(1, 30, 1, 1, 0); chk("flush_acq_ready", o_acquire_ready, 0);
                              chk("flush_alloc_valid", o_alloc_valid, 0);
                              chk("flush_draining", o_draining, 0);
                              chk("flush_count", o_count, 3);
        step(1, 30, 1, 0, 1); chk("d0_draining", o_draining, 1);
                              chk("d0_aband_valid", o_abandoned_valid, 1);
                              chk("d0_aband_prf", o_abandoned_prf, 20);
                              chk("d0_acq_ready", o_acquire_ready, 0);
                              chk("d0_alloc_valid", o_alloc_valid, 0);
        step(0, 0, 0, 1, 0);  chk("d1_aband_prf", o_abandoned_prf, 22);
                              chk("d1_count", o_count, 2);
        step(0, 0, 0, 0, 1);  chk("d2_aband_prf", o_abandoned_prf, 22);
                              chk("d2_draining", o_draining, 1);
        step(0, 0, 0, 0, 1);  chk("d3_aband_prf", o_abandoned_prf, 24);
                              chk("d3_count", o_count, 1);
        step(0, 0, 0, 0, 0);  chk("post_drain_draining", o_draining, 0);
                              chk("post_drain_count", o_count, 0);
                              chk("post_drain_aband_valid", o_abandoned_valid, 0);
                              chk("post_drain_acq_ready", o_acquire_ready, 1);

        // Flush on empty queue: no drain; then acquire 40 with rename ready.
        step(1, 40, 1, 1, 0); chk("eflush_acq_ready", o_acquire_ready, 0);
        step(1, 40, 1, 0, 0); chk("eflush_draining", o_draining, 0);
                              chk("eflush_aband_valid", o_abandoned_valid, 0);
                              chk("eflush_acq_ready2", o_acquire_ready, 1);
`ifdef ISSUE_RAT_PREFETCH_BYPASS_EN
                              chk("bypass_valid", o_alloc_valid, 1);
                              chk("bypass_prf", o_alloc_prf, 40);
        step(0, 0, 1, 0, 0);  chk("bypass_count", o_count, 0);
                              chk("bypass_valid_after", o_alloc_valid, 0);
`else
                              chk("nobypass_valid0", o_alloc_valid, 0);
        step(0, 0, 1, 0, 0);  chk("nobypass_count", o_count, 1);
                              chk("nobypass_valid1", o_alloc_valid, 1);
                              chk("nobypass_prf", o_alloc_prf, 40);
        step(0, 0, 0, 0, 0);  chk("nobypass_count_end", o_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
